// File: rtl/trng_pkg.sv
// Shared types and default parameters for the TRNG bit source.
package trng_pkg;

  localparam int unsigned TRNG_SAMPLE_DIV = 4;
  localparam int unsigned TRNG_REP_LIMIT  = 32;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    HOLD
  } trng_state_e;

endpackage

// File: rtl/trng_sync.sv
// Two-flop synchronizer that brings the asynchronous raw entropy line into the CLK domain.
module trng_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/trng_bit_src.sv
// Von Neumann debiased entropy bit source with a RANDOM/BIT_READY/ACK handshake.
// Optional repetition-count health test is built when TRNG_HEALTH_EN is defined.
module trng_bit_src
  import trng_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = TRNG_SAMPLE_DIV,
  parameter int unsigned REP_LIMIT  = TRNG_REP_LIMIT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  input  logic RAW,
  input  logic ACK,
  output logic RANDOM,
  output logic BIT_READY,
  output logic FAULT
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  if ((SAMPLE_DIV < 2) || (REP_LIMIT < 2)) begin : g_param_chk
    $error("trng_bit_src: SAMPLE_DIV and REP_LIMIT must both be at least 2");
  end

  logic              raw_s;
  logic              tick_c;
  logic              health_fault;
  trng_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              first_q;

  trng_sync u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (RAW),
    .q     (raw_s)
  );

  assign tick_c = ((state_q == FIRST) || (state_q == SECOND)) &&
                  (cnt_q == CNT_W'(SAMPLE_DIV - 1));

  // Pair extractor and handshake; EN low aborts any partial pair but keeps RANDOM.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      RANDOM    <= 1'b0;
      BIT_READY <= 1'b0;
    end else if (!EN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      BIT_READY <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FIRST;
          cnt_q   <= '0;
        end
        FIRST: begin
          cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
          if (tick_c && !health_fault) begin
            first_q <= raw_s;
            state_q <= SECOND;
          end
        end
        SECOND: begin
          cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
          if (tick_c) begin
            if (!health_fault && (raw_s != first_q)) begin
              RANDOM    <= first_q;
              BIT_READY <= 1'b1;
              state_q   <= HOLD;
              cnt_q     <= '0;
            end else begin
              state_q <= FIRST;
            end
          end
        end
        HOLD: begin
          cnt_q <= '0;
          if (ACK) begin
            BIT_READY <= 1'b0;
            state_q   <= FIRST;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          BIT_READY <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRNG_HEALTH_EN
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  logic [REP_W-1:0] rep_q;
  logic             prev_q;

  // Repetition count over consecutive samples; the fault latches until reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rep_q        <= '0;
      prev_q       <= 1'b0;
      health_fault <= 1'b0;
    end else begin
      if (tick_c) begin
        prev_q <= raw_s;
        if (raw_s != prev_q) begin
          rep_q <= REP_W'(1);
        end else if (rep_q != REP_W'(REP_LIMIT)) begin
          rep_q <= rep_q + REP_W'(1);
        end
      end
      if (rep_q == REP_W'(REP_LIMIT)) begin
        health_fault <= 1'b1;
      end
    end
  end
`else
  assign health_fault = 1'b0;
`endif

  assign FAULT = health_fault;

endmodule

// File: tb/tb_trng_bit_src.sv
// Directed self-checking bench for trng_bit_src at SAMPLE_DIV=4, REP_LIMIT=32.
module tb_trng_bit_src;

`ifdef TRNG_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  logic EN;
  logic RAW;
  logic ACK;
  logic RANDOM;
  logic BIT_READY;
  logic FAULT;

  int n_checks = 0;
  int n_fail   = 0;

  trng_bit_src #(
    .SAMPLE_DIV (4),
    .REP_LIMIT  (32)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .RAW       (RAW),
    .ACK       (ACK),
    .RANDOM    (RANDOM),
    .BIT_READY (BIT_READY),
    .FAULT     (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called just after the edge that entered FIRST with a cleared divider.
  // Presents one raw pair aligned to the two ticks; ends just after the second tick.
  task automatic pair(input string tag, input logic b1, input logic b2);
    RAW = b1;
    step(4);
    RAW = b2;
    step(3);
    check_eq({tag, "_early"}, BIT_READY, 1'b0);
    step(1);
  endtask

  initial begin
    logic saw_ready;
    logic stable;

    RST_N = 1'b0;
    EN    = 1'b0;
    RAW   = 1'b0;
    ACK   = 1'b0;
    step(2);
    check_eq("rst_random", RANDOM, 1'b0);
    check_eq("rst_ready", BIT_READY, 1'b0);
    check_eq("rst_fault", FAULT, 1'b0);
    RST_N = 1'b1;
    step(2);

    // Pair 10 -> 1, ready exactly two sample periods after enable.
    EN = 1'b1;
    step(1);
    pair("p10", 1'b1, 1'b0);
    check_eq("p10_ready", BIT_READY, 1'b1);
    check_eq("p10_random", RANDOM, 1'b1);

    ACK = 1'b1;
    step(1);
    ACK = 1'b0;
    check_eq("ack1_ready", BIT_READY, 1'b0);
    check_eq("ack1_random_kept", RANDOM, 1'b1);

    // Pair 01 -> 0.
    pair("p01", 1'b0, 1'b1);
    check_eq("p01_ready", BIT_READY, 1'b1);
    check_eq("p01_random", RANDOM, 1'b0);
    ACK = 1'b1;
    step(1);
    ACK = 1'b0;
    check_eq("ack2_ready", BIT_READY, 1'b0);

    // 11 and 00 discarded, 10 accepted after three pairs.
    pair("p11", 1'b1, 1'b1);
    check_eq("p11_ready", BIT_READY, 1'b0);
    pair("p00", 1'b0, 1'b0);
    check_eq("p00_ready", BIT_READY, 1'b0);
    pair("p10b", 1'b1, 1'b0);
    check_eq("p10b_ready", BIT_READY, 1'b1);
    check_eq("p10b_random", RANDOM, 1'b1);

    // Hold the bit 50 cycles with RAW toggling and no ACK.
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      RAW = ~RAW;
      step(1);
      if ((BIT_READY !== 1'b1) || (RANDOM !== 1'b1)) stable = 1'b0;
    end
    check_eq("hold_stable", stable, 1'b1);
    ACK = 1'b1;
    step(1);
    ACK = 1'b0;
    check_eq("ack3_ready", BIT_READY, 1'b0);
    pair("after_ack", 1'b0, 1'b1);
    check_eq("after_ack_ready", BIT_READY, 1'b1);
    check_eq("after_ack_random", RANDOM, 1'b0);
    ACK = 1'b1;
    step(1);
    ACK = 1'b0;

    // EN dropped during SECOND: partial pair lost, fresh pair needed.
    RAW = 1'b1;
    step(6);
    EN = 1'b0;
    step(1);
    check_eq("en_sec_ready", BIT_READY, 1'b0);
    step(2);
    EN = 1'b1;
    step(1);
    pair("en_sec_fresh", 1'b0, 1'b1);
    check_eq("en_sec_fresh_ready", BIT_READY, 1'b1);
    check_eq("en_sec_fresh_random", RANDOM, 1'b0);

    // EN dropped during HOLD, with ACK on the same edge: EN wins, RANDOM kept.
    EN  = 1'b0;
    ACK = 1'b1;
    step(1);
    ACK = 1'b0;
    check_eq("en_hold_ready", BIT_READY, 1'b0);
    check_eq("en_hold_random", RANDOM, 1'b0);
    step(2);
    EN = 1'b1;
    step(1);
    pair("en_hold_fresh", 1'b1, 1'b0);
    check_eq("en_hold_fresh_ready", BIT_READY, 1'b1);
    check_eq("en_hold_fresh_random", RANDOM, 1'b1);

    // ACK held high consumes the bit the cycle after it appears.
    ACK = 1'b1;
    step(1);
    check_eq("ackhi_first_ready", BIT_READY, 1'b0);
    pair("ackhi", 1'b0, 1'b1);
    check_eq("ackhi_ready", BIT_READY, 1'b1);
    check_eq("ackhi_random", RANDOM, 1'b0);
    step(1);
    check_eq("ackhi_consumed", BIT_READY, 1'b0);
    ACK = 1'b0;

    // Reset pulse with a pending bit; no stale bit after re-enable.
    pair("pre_rst", 1'b1, 1'b0);
    check_eq("pre_rst_ready", BIT_READY, 1'b1);
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
    check_eq("mid_rst_ready", BIT_READY, 1'b0);
    check_eq("mid_rst_random", RANDOM, 1'b0);
    check_eq("mid_rst_fault", FAULT, 1'b0);
    step(1);
    pair("post_rst", 1'b0, 1'b1);
    check_eq("post_rst_ready", BIT_READY, 1'b1);
    check_eq("post_rst_random", RANDOM, 1'b0);

    // Stuck RAW=1: health fault after the 32nd tick when built in, never otherwise.
    RST_N = 1'b0;
    EN    = 1'b0;
    RAW   = 1'b1;
    step(2);
    RST_N = 1'b1;
    EN    = 1'b1;
    step(1);
    saw_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      step(1);
      if (BIT_READY !== 1'b0) saw_ready = 1'b1;
    end
    check_eq("stuck_no_ready", saw_ready, 1'b0);
    check_eq("stuck_fault_t32", FAULT, 1'b0);
    step(1);
    check_eq("stuck_fault_t33", FAULT, HEALTH);
    EN = 1'b0;
    step(2);
    EN = 1'b1;
    step(1);
    check_eq("fault_after_en", FAULT, HEALTH);
    pair("fault_pair", 1'b1, 1'b0);
    check_eq("fault_pair_ready", BIT_READY, !HEALTH);
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
    check_eq("fault_cleared", FAULT, 1'b0);
    check_eq("fault_rst_ready", BIT_READY, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
